// File: rtl/tsn_sp_grant_fsm.sv
// Strict-priority grant stage behind the Qav credit manager.
// Grants one queue per frame, holds it until the last beat, then enforces an inter-frame gap.
module tsn_sp_grant_fsm #(
    parameter int PORT_FIFO_PRI_NUM = 8,
    parameter int WAIT_TIMEOUT      = 64,
    parameter int IFG_CYCLES        = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [PORT_FIFO_PRI_NUM:0] i_queque,
    input  logic                       i_queque_vld,
    input  logic [PORT_FIFO_PRI_NUM:0] i_fifoc_empty,
    input  logic [PORT_FIFO_PRI_NUM:0] i_gate_state,
    input  logic                       i_pmac_tx_axis_valid,
    input  logic                       i_pmac_tx_axis_ready,
    input  logic                       i_pmac_tx_axis_last,
    output logic [PORT_FIFO_PRI_NUM:0] o_scheduing_rst,
    output logic                       o_scheduing_rst_vld,
    output logic                       o_busy,
    output logic                       o_timeout_err
);

    localparam int W = PORT_FIFO_PRI_NUM + 1;
    localparam logic [15:0] TO_LAST  = 16'(WAIT_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        TX,
        GAP
    } state_t;

    state_t         state;
    logic [W-1:0]   cand;
    logic [W-1:0]   eligible;
    logic [W-1:0]   grant;
    logic [15:0]    cnt;
    logic [15:0]    cnt_inc;
    logic           beat;

    assign eligible = cand & i_gate_state & ~i_fifoc_empty;
    assign beat     = i_pmac_tx_axis_valid & i_pmac_tx_axis_ready;
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign o_busy   = (state != IDLE);

    // Later (higher) indices overwrite, so the highest eligible bit wins.
    always_comb begin
        grant = '0;
        for (int i = 0; i < W; i++) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state               <= IDLE;
            cand                <= '0;
            cnt                 <= '0;
            o_scheduing_rst     <= '0;
            o_scheduing_rst_vld <= 1'b0;
            o_timeout_err       <= 1'b0;
        end else begin
            if (i_queque_vld)
                cand <= i_queque;
            o_scheduing_rst_vld <= 1'b0;
            o_timeout_err       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        o_scheduing_rst     <= grant;
                        o_scheduing_rst_vld <= 1'b1;
                        cnt                 <= '0;
                        state               <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    // A beat on the terminal-count cycle wins over the timeout.
                    if (beat) begin
                        cnt   <= '0;
                        state <= i_pmac_tx_axis_last ? GAP : TX;
                    end else if (cnt_inc >= TO_LAST) begin
                        o_timeout_err <= 1'b1;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                TX: begin
                    if (beat && i_pmac_tx_axis_last) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt >= GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
